// File: rtl/transmit_frame_sequencer.sv
// Transmit frame sequencer: opens a packet toward the DMA, streams the sensor
// payload from an async-read RAM under sink_ready backpressure, hands off to the
// ok_rx/CRC trailer, waits for endofpacket, enforces an inter-frame gap and
// counts completed frames.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start
// SOT     | one-cycle start-of-transfer pulse, address parked at 0
// READ    | payload phase, address advances on each accepted byte
// TRAILER | EoR pulse on entry, waiting for eop_in or the timeout
// GAP     | inter-frame idle time before start is accepted again
module transmit_frame_sequencer #(
    parameter int SENSORS_NUMBER   = 16,
    parameter int BYTES_PER_SENSOR = 4,
    parameter int ADDR_W           = 10,
    parameter int GAP_CYCLES       = 4,
    parameter int TIMEOUT          = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sink_ready,
    input  logic              eop_in,
    output logic              SoT_to_DMA,
    output logic              rd_en_without_DMA_ready,
    output logic              rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              EoR_from_Mem,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic              start_dropped,
    output logic              timeout_err
);

    localparam int N      = SENSORS_NUMBER * BYTES_PER_SENSOR;
    localparam int WAIT_W = $clog2(TIMEOUT) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]  GAP_MAX   = GAP_W'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SOT     = 3'd1,
        S_READ    = 3'd2,
        S_TRAILER = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [15:0]       fcnt_q, fcnt_d;
    logic              sd_q, sd_d;
    logic              terr_q, terr_d;

    // State and counter registers; reset drops any frame in flight without closing it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
            fcnt_q  <= '0;
            sd_q    <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wait_q  <= wait_d;
            gap_q   <= gap_d;
            fcnt_q  <= fcnt_d;
            sd_q    <= sd_d;
            terr_q  <= terr_d;
        end
    end

    // Next-state and counter update. The wait counter holds 1 in the first TRAILER
    // cycle, so reaching TIMEOUT means TIMEOUT TRAILER cycles have elapsed.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wait_d  = wait_q;
        gap_d   = gap_q;
        fcnt_d  = fcnt_q;
        sd_d    = sd_q | (start & (state_q != S_IDLE));
        terr_d  = terr_q;
        case (state_q)
            S_IDLE: begin
                addr_d = '0;
                if (start) state_d = S_SOT;
            end
            S_SOT: begin
                addr_d  = '0;
                state_d = S_READ;
            end
            S_READ: begin
                if (sink_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        addr_d  = '0;
                        wait_d  = WAIT_W'(1);
                        state_d = S_TRAILER;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end
            end
            S_TRAILER: begin
                if (eop_in) begin
                    fcnt_d = fcnt_q + 16'd1;
                    gap_d  = GAP_W'(1);
                    if (GAP_CYCLES == 0) state_d = S_IDLE;
                    else                 state_d = S_GAP;
                end else if (wait_q == WAIT_MAX) begin
                    terr_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_GAP: begin
                if (gap_q == GAP_MAX) state_d = S_IDLE;
                else                  gap_d   = gap_q + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from registers; only rd_en follows sink_ready combinationally.
    always_comb begin
        SoT_to_DMA              = (state_q == S_SOT);
        rd_en_without_DMA_ready = (state_q == S_READ);
        rd_en                   = (state_q == S_READ) & sink_ready;
        mem_rd_addr             = addr_q;
        EoR_from_Mem            = (state_q == S_TRAILER) & (wait_q == WAIT_W'(1));
        busy                    = (state_q != S_IDLE);
        frame_cnt               = fcnt_q;
        start_dropped           = sd_q;
        timeout_err             = terr_q;
    end

endmodule

// File: tb/tb_transmit_frame_sequencer.sv
// Directed bench for transmit_frame_sequencer: a table of frame scenarios
// (backpressure, eop timing, dropped starts, timeout) plus hand-written reset
// sequences.
module tb_transmit_frame_sequencer;

    localparam int ADDR_W  = 10;
    localparam int N       = 64;
    localparam int GAP     = 4;
    localparam int TMO     = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              sink_ready = 1'b0;
    logic              eop_in = 1'b0;
    logic              SoT_to_DMA;
    logic              rd_en_without_DMA_ready;
    logic              rd_en;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              EoR_from_Mem;
    logic              busy;
    logic [15:0]       frame_cnt;
    logic              start_dropped;
    logic              timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    transmit_frame_sequencer #(
        .SENSORS_NUMBER(16), .BYTES_PER_SENSOR(4), .ADDR_W(ADDR_W),
        .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sink_ready(sink_ready),
        .eop_in(eop_in), .SoT_to_DMA(SoT_to_DMA),
        .rd_en_without_DMA_ready(rd_en_without_DMA_ready), .rd_en(rd_en),
        .mem_rd_addr(mem_rd_addr), .EoR_from_Mem(EoR_from_Mem), .busy(busy),
        .frame_cnt(frame_cnt), .start_dropped(start_dropped), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // bp: 1,0,0,1 sink_ready pattern; eop_at: TRAILER cycle carrying eop_in (0 = never);
    // inj_*: cycle index in READ / GAP with start asserted (-1 = none);
    // exp_*: values expected once the frame has finished.
    typedef struct {
        bit bp;
        int eop_at;
        int inj_read;
        int inj_gap;
        int exp_fcnt;
        bit exp_terr;
        bit exp_sd;
    } frame_vec_t;

    frame_vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic st, input logic sr, input logic eo);
        @(negedge clk);
        start = st;
        sink_ready = sr;
        eop_in = eo;
        #1;
    endtask

    // IDLE cycle: check frame-level status, optionally request the next frame.
    task automatic idle_cycle(input int ef, input bit et, input bit es, input bit go);
        cyc(go, 1'b1, 1'b0);
        chk("idle_busy", busy, 0);
        chk("idle_sot", SoT_to_DMA, 0);
        chk("idle_rd_en", rd_en, 0);
        chk("idle_frame_cnt", frame_cnt, ef);
        chk("idle_timeout_err", timeout_err, et);
        chk("idle_start_dropped", start_dropped, es);
    endtask

    // Everything from the SOT cycle to the last GAP/TRAILER cycle.
    task automatic frame_body(input frame_vec_t v);
        logic [3:0] pat;
        logic       sr;
        logic       eo;
        int         exp_addr;
        int         i;
        pat = 4'b1001;
        cyc(1'b0, 1'b1, 1'b0);
        chk("sot_pulse", SoT_to_DMA, 1);
        chk("sot_busy", busy, 1);
        chk("sot_addr", mem_rd_addr, 0);
        chk("sot_rd_en", rd_en, 0);
        exp_addr = 0;
        i = 0;
        while (exp_addr < N && i < 400) begin
            sr = v.bp ? pat[i % 4] : 1'b1;
            cyc((i == v.inj_read), sr, 1'b0);
            chk("read_phase", rd_en_without_DMA_ready, 1);
            chk("read_rd_en", rd_en, sr);
            chk("read_addr", mem_rd_addr, exp_addr);
            chk("read_sot", SoT_to_DMA, 0);
            chk("read_eor", EoR_from_Mem, 0);
            if (sr) exp_addr++;
            i++;
        end
        if (exp_addr < N) begin
            n_cmp++;
            n_bad++;
            $display("FAIL read_budget: accepted %0d, expected %0d", exp_addr, N);
        end
        for (int t = 1; t <= TMO; t++) begin
            eo = (t == v.eop_at);
            cyc(1'b0, 1'b1, eo);
            chk("trl_eor", EoR_from_Mem, (t == 1));
            chk("trl_rd_en", rd_en, 0);
            chk("trl_phase", rd_en_without_DMA_ready, 0);
            chk("trl_addr", mem_rd_addr, 0);
            chk("trl_busy", busy, 1);
            if (eo) break;
        end
        if (v.eop_at > 0) begin
            for (int g = 1; g <= GAP; g++) begin
                cyc((g == v.inj_gap), 1'b0, 1'b0);
                chk("gap_busy", busy, 1);
                chk("gap_frame_cnt", frame_cnt, v.exp_fcnt);
                chk("gap_sot", SoT_to_DMA, 0);
            end
        end
    endtask

    initial begin
        int ef;
        bit et;
        bit es;

        vecs[0] = '{bp: 1'b0, eop_at: 4, inj_read: -1, inj_gap: -1, exp_fcnt: 1, exp_terr: 1'b0, exp_sd: 1'b0};
        vecs[1] = '{bp: 1'b1, eop_at: 1, inj_read: 5,  inj_gap: 2,  exp_fcnt: 2, exp_terr: 1'b0, exp_sd: 1'b1};
        vecs[2] = '{bp: 1'b0, eop_at: 0, inj_read: -1, inj_gap: -1, exp_fcnt: 2, exp_terr: 1'b1, exp_sd: 1'b1};
        vecs[3] = '{bp: 1'b0, eop_at: 8, inj_read: -1, inj_gap: -1, exp_fcnt: 3, exp_terr: 1'b1, exp_sd: 1'b1};
        vecs[4] = '{bp: 1'b1, eop_at: 2, inj_read: -1, inj_gap: -1, exp_fcnt: 4, exp_terr: 1'b1, exp_sd: 1'b1};

        // Reset held with start and sink_ready high: all outputs stay 0.
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b1, 1'b1, 1'b1);
            chk("rst_busy", busy, 0);
            chk("rst_sot", SoT_to_DMA, 0);
            chk("rst_rd_en", rd_en, 0);
            chk("rst_phase", rd_en_without_DMA_ready, 0);
            chk("rst_eor", EoR_from_Mem, 0);
            chk("rst_addr", mem_rd_addr, 0);
            chk("rst_frame_cnt", frame_cnt, 0);
            chk("rst_flags", {start_dropped, timeout_err}, 0);
        end
        @(negedge clk);
        start = 1'b0;
        eop_in = 1'b0;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0);
            chk("post_rst_busy", busy, 0);
            chk("post_rst_sot", SoT_to_DMA, 0);
        end

        // Table-driven frames; each frame starts in the first IDLE cycle of the previous one.
        ef = 0;
        et = 1'b0;
        es = 1'b0;
        for (int i = 0; i < 5; i++) begin
            idle_cycle(ef, et, es, 1'b1);
            frame_body(vecs[i]);
            ef = vecs[i].exp_fcnt;
            et = vecs[i].exp_terr;
            es = vecs[i].exp_sd;
        end
        idle_cycle(ef, et, es, 1'b0);

        // Async reset mid-READ at address 17; the next frame restarts from address 0.
        idle_cycle(ef, et, es, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        chk("mr_sot", SoT_to_DMA, 1);
        for (int k = 0; k < 17; k++) cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("mr_addr_before", mem_rd_addr, 17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_busy", busy, 0);
        chk("mr_addr", mem_rd_addr, 0);
        chk("mr_phase", rd_en_without_DMA_ready, 0);
        chk("mr_frame_cnt", frame_cnt, 0);
        chk("mr_flags", {start_dropped, timeout_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle(0, 1'b0, 1'b0, 1'b1);
        frame_body('{bp: 1'b0, eop_at: 3, inj_read: -1, inj_gap: -1, exp_fcnt: 1, exp_terr: 1'b0, exp_sd: 1'b0});
        idle_cycle(1, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
